tdp36k_split_ram: RTL and testbench

- Dual independent 18Kb true-dual-port block RAM (split mode of the 36K BRAM tile), all four ports on one clock.
- Each half (RAM1, RAM2) is 1024 rows x 18 bits: data[15:0] plus parity[17:16].
- Ports A and B per half have independently configurable read/write widths (x18, x9, x4, x2, x1).
- Sits under the TDP_RAM18KX2 primitive-mapping wrapper.

---
 rtl/tdp36k_pkg.sv | 86 ++++++++
 rtl/tdp18k_half.sv | 112 +++++++++++
 rtl/tdp36k_split_ram.sv | 88 ++++++++
 tb/tb_tdp36k_split_ram.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdp36k_pkg.sv
// Shared definitions for the split-mode 36K block RAM: width codes, MODE_BITS
// field offsets, the row type and the lane helpers used by both halves.
package tdp36k_pkg;

    // Port width codes carried in MODE_BITS
    localparam logic [2:0] WCODE_X18 = 3'b010;
    localparam logic [2:0] WCODE_X9  = 3'b100;
    localparam logic [2:0] WCODE_X4  = 3'b001;
    localparam logic [2:0] WCODE_X2  = 3'b011;
    localparam logic [2:0] WCODE_X1  = 3'b101;

    // LSB positions of the 3-bit width fields inside MODE_BITS
    localparam int RM_A1_LSB = 77;
    localparam int RM_B1_LSB = 74;
    localparam int WM_A1_LSB = 71;
    localparam int WM_B1_LSB = 68;
    localparam int RM_A2_LSB = 36;
    localparam int RM_B2_LSB = 33;
    localparam int WM_A2_LSB = 30;
    localparam int WM_B2_LSB = 27;

    localparam int ROWS      = 1024;
    localparam int ROW_W     = 18;
    localparam int HALF_BITS = ROWS * ROW_W;

    // One memory row: {parity[1:0], data[15:0]}
    typedef logic [ROW_W-1:0] row_t;

    // Width code to port width; unknown codes behave as x18
    function automatic int unsigned code_width(input logic [2:0] code);
        case (code)
            WCODE_X9: return 9;
            WCODE_X4: return 4;
            WCODE_X2: return 2;
            WCODE_X1: return 1;
            default:  return 18;
        endcase
    endfunction

    // All-ones value w bits wide, for narrow ports
    function automatic logic [15:0] low_ones(input int unsigned w);
        return 16'((32'd1 << w) - 32'd1);
    endfunction

    // Bit offset into data[15:0] picked by the address bits below the row select
    function automatic logic [3:0] lane_offset(input int unsigned w, input logic [3:0] bit_addr);
        case (w)
            9:       return bit_addr & 4'b1000;
            4:       return bit_addr & 4'b1100;
            2:       return bit_addr & 4'b1110;
            1:       return bit_addr;
            default: return 4'd0;
        endcase
    endfunction

    // Row bits a write touches; narrow and x9 writes are gated by BE[0] alone
    function automatic row_t write_mask(input int unsigned w, input logic [3:0] off,
                                        input logic [1:0] be);
        row_t m;
        m = '0;
        if (w == 18) begin
            m = {be[1], be[0], {8{be[1]}}, {8{be[0]}}};
        end else if (be[0]) begin
            if (w == 9) m = {off[3], ~off[3], 16'h00FF << off};
            else        m = {2'b00, low_ones(w) << off};
        end
        return m;
    endfunction

    // Write data placed at its row position; write_mask picks the live bits
    function automatic row_t write_data(input int unsigned w, input logic [3:0] off,
                                        input row_t wdata);
        if (w == 18) return wdata;
        if (w == 9)  return {wdata[16], wdata[16], wdata[7:0], wdata[7:0]};
        return {2'b00, wdata[15:0] << off};
    endfunction

    // Row contents right-aligned for the reading port's width
    function automatic row_t read_align(input int unsigned w, input logic [3:0] off,
                                        input row_t row);
        if (w == 18) return row;
        if (w == 9)  return {1'b0, (off[3] ? row[17] : row[16]), 8'h00, 8'(row[15:0] >> off)};
        return {2'b00, (row[15:0] >> off) & low_ones(w)};
    endfunction

endpackage

// File: rtl/tdp18k_half.sv
// One 1024x18 true-dual-port half: per-port width decode, lane masking,
// B-wins write merge and registered read data.
// Optional macro TDP36K_OUT_REG_EN adds a second read-data register stage.
module tdp18k_half
    import tdp36k_pkg::*;
#(
    parameter logic [HALF_BITS-1:0] INIT = '0,
    parameter logic [2:0]           RM_A = WCODE_X18,
    parameter logic [2:0]           RM_B = WCODE_X18,
    parameter logic [2:0]           WM_A = WCODE_X18,
    parameter logic [2:0]           WM_B = WCODE_X18
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        wen_a_i,
    input  logic        ren_a_i,
    input  logic [1:0]  be_a_i,
    input  logic [13:0] addr_a_i,
    input  row_t        wdata_a_i,
    output row_t        rdata_a_o,
    input  logic        wen_b_i,
    input  logic        ren_b_i,
    input  logic [1:0]  be_b_i,
    input  logic [13:0] addr_b_i,
    input  row_t        wdata_b_i,
    output row_t        rdata_b_o
);

    localparam int unsigned W_RA = code_width(RM_A);
    localparam int unsigned W_RB = code_width(RM_B);
    localparam int unsigned W_WA = code_width(WM_A);
    localparam int unsigned W_WB = code_width(WM_B);

    typedef row_t mem_t [ROWS];

    function automatic mem_t unpack_init(input logic [HALF_BITS-1:0] bits);
        mem_t m;
        for (int r = 0; r < ROWS; r++) m[r] = bits[ROW_W*r +: ROW_W];
        return m;
    endfunction

    // Contents come from INIT at time zero; reset never touches them
    mem_t mem_q = unpack_init(INIT);

    logic [9:0] row_a, row_b;
    row_t       mask_a, mask_b, merged_a, merged_b, base_b;
    row_t       rdata_a_d, rdata_b_d, rdata_a_q, rdata_b_q;

    assign row_a = addr_a_i[13:4];
    assign row_b = addr_b_i[13:4];

    // Merge each port's write into its row; on a shared row B is applied over A
    always_comb begin
        mask_a   = write_mask(W_WA, lane_offset(W_WA, addr_a_i[3:0]), be_a_i);
        mask_b   = write_mask(W_WB, lane_offset(W_WB, addr_b_i[3:0]), be_b_i);
        merged_a = (mem_q[row_a] & ~mask_a)
                 | (write_data(W_WA, lane_offset(W_WA, addr_a_i[3:0]), wdata_a_i) & mask_a);
        base_b   = (wen_a_i && (row_a == row_b)) ? merged_a : mem_q[row_b];
        merged_b = (base_b & ~mask_b)
                 | (write_data(W_WB, lane_offset(W_WB, addr_b_i[3:0]), wdata_b_i) & mask_b);
    end

    // Memory update; B is written last so it carries A's bits on a shared row
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (wen_a_i) mem_q[row_a] <= merged_a;
            if (wen_b_i) mem_q[row_b] <= merged_b;
        end
    end

    // Read-data next state: reset/flush clear, enabled read loads pre-write contents
    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (rst_i || flush_i) begin
            rdata_a_d = '0;
            rdata_b_d = '0;
        end else begin
            if (ren_a_i) rdata_a_d = read_align(W_RA, lane_offset(W_RA, addr_a_i[3:0]), mem_q[row_a]);
            if (ren_b_i) rdata_b_d = read_align(W_RB, lane_offset(W_RB, addr_b_i[3:0]), mem_q[row_b]);
        end
    end

    // First read-data register stage
    always_ff @(posedge clk_i) begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
    end

`ifdef TDP36K_OUT_REG_EN
    row_t rdata_a2_q, rdata_b2_q;

    // Output stage advances every cycle and clears with reset or flush
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rdata_a2_q <= '0;
            rdata_b2_q <= '0;
        end else begin
            rdata_a2_q <= rdata_a_q;
            rdata_b2_q <= rdata_b_q;
        end
    end

    assign rdata_a_o = rdata_a2_q;
    assign rdata_b_o = rdata_b2_q;
`else
    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
`endif

endmodule

// File: rtl/tdp36k_split_ram.sv
// Split-mode 36K block RAM: two independent 18Kb true-dual-port halves on one
// clock. Each half takes its slice of INIT_i and its width fields of MODE_BITS.
// Optional macro TDP36K_OUT_REG_EN raises read latency from 1 to 2.
module tdp36k_split_ram
    import tdp36k_pkg::*;
#(
    parameter logic [80:0]    MODE_BITS = 81'd1,
    parameter logic [36863:0] INIT_i    = 36864'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WEN_A1,
    input  logic        WEN_B1,
    input  logic        WEN_A2,
    input  logic        WEN_B2,
    input  logic        REN_A1,
    input  logic        REN_B1,
    input  logic        REN_A2,
    input  logic        REN_B2,
    input  logic [1:0]  BE_A1,
    input  logic [1:0]  BE_B1,
    input  logic [1:0]  BE_A2,
    input  logic [1:0]  BE_B2,
    input  logic [13:0] ADDR_A1,
    input  logic [13:0] ADDR_B1,
    input  logic [13:0] ADDR_A2,
    input  logic [13:0] ADDR_B2,
    input  logic [17:0] WDATA_A1,
    input  logic [17:0] WDATA_B1,
    input  logic [17:0] WDATA_A2,
    input  logic [17:0] WDATA_B2,
    output logic [17:0] RDATA_A1,
    output logic [17:0] RDATA_B1,
    output logic [17:0] RDATA_A2,
    output logic [17:0] RDATA_B2,
    input  logic        FLUSH1,
    input  logic        FLUSH2
);

    tdp18k_half #(
        .INIT (INIT_i[0 +: HALF_BITS]),
        .RM_A (MODE_BITS[RM_A1_LSB +: 3]),
        .RM_B (MODE_BITS[RM_B1_LSB +: 3]),
        .WM_A (MODE_BITS[WM_A1_LSB +: 3]),
        .WM_B (MODE_BITS[WM_B1_LSB +: 3])
    ) u_ram1 (
        .clk_i     (CLK),
        .rst_i     (RST),
        .flush_i   (FLUSH1),
        .wen_a_i   (WEN_A1),
        .ren_a_i   (REN_A1),
        .be_a_i    (BE_A1),
        .addr_a_i  (ADDR_A1),
        .wdata_a_i (WDATA_A1),
        .rdata_a_o (RDATA_A1),
        .wen_b_i   (WEN_B1),
        .ren_b_i   (REN_B1),
        .be_b_i    (BE_B1),
        .addr_b_i  (ADDR_B1),
        .wdata_b_i (WDATA_B1),
        .rdata_b_o (RDATA_B1)
    );

    tdp18k_half #(
        .INIT (INIT_i[HALF_BITS +: HALF_BITS]),
        .RM_A (MODE_BITS[RM_A2_LSB +: 3]),
        .RM_B (MODE_BITS[RM_B2_LSB +: 3]),
        .WM_A (MODE_BITS[WM_A2_LSB +: 3]),
        .WM_B (MODE_BITS[WM_B2_LSB +: 3])
    ) u_ram2 (
        .clk_i     (CLK),
        .rst_i     (RST),
        .flush_i   (FLUSH2),
        .wen_a_i   (WEN_A2),
        .ren_a_i   (REN_A2),
        .be_a_i    (BE_A2),
        .addr_a_i  (ADDR_A2),
        .wdata_a_i (WDATA_A2),
        .rdata_a_o (RDATA_A2),
        .wen_b_i   (WEN_B2),
        .ren_b_i   (REN_B2),
        .be_b_i    (BE_B2),
        .addr_b_i  (ADDR_B2),
        .wdata_b_i (WDATA_B2),
        .rdata_b_o (RDATA_B2)
    );

endmodule

// File: tb/tb_tdp36k_split_ram.sv
// Directed bench for tdp36k_split_ram.
// Port widths: A1 read x4 / write x18, B1 read x18 / write x1,
//              A2 read x18 / write x9, B2 read x18 / write x2.
// INIT: RAM2 row 3 = 0x3FFFF, everything else 0.
module tb_tdp36k_split_ram;

    localparam logic [80:0] MODE = (81'b001 << 77) | (81'b010 << 74) | (81'b010 << 71)
                                 | (81'b101 << 68) | (81'b010 << 36) | (81'b010 << 33)
                                 | (81'b100 << 30) | (81'b011 << 27) | 81'd1;
    localparam logic [36863:0] INIT = 36864'h3FFFF << (18432 + 3 * 18);

    logic        clk;
    logic        rst;
    logic        wen_a1, wen_b1, wen_a2, wen_b2;
    logic        ren_a1, ren_b1, ren_a2, ren_b2;
    logic [1:0]  be_a1, be_b1, be_a2, be_b2;
    logic [13:0] addr_a1, addr_b1, addr_a2, addr_b2;
    logic [17:0] wdata_a1, wdata_b1, wdata_a2, wdata_b2;
    logic [17:0] rdata_a1, rdata_b1, rdata_a2, rdata_b2;
    logic        flush1, flush2;

    int total = 0;
    int bad   = 0;

    tdp36k_split_ram #(
        .MODE_BITS (MODE),
        .INIT_i    (INIT)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .WEN_A1   (wen_a1),
        .WEN_B1   (wen_b1),
        .WEN_A2   (wen_a2),
        .WEN_B2   (wen_b2),
        .REN_A1   (ren_a1),
        .REN_B1   (ren_b1),
        .REN_A2   (ren_a2),
        .REN_B2   (ren_b2),
        .BE_A1    (be_a1),
        .BE_B1    (be_b1),
        .BE_A2    (be_a2),
        .BE_B2    (be_b2),
        .ADDR_A1  (addr_a1),
        .ADDR_B1  (addr_b1),
        .ADDR_A2  (addr_a2),
        .ADDR_B2  (addr_b2),
        .WDATA_A1 (wdata_a1),
        .WDATA_B1 (wdata_b1),
        .WDATA_A2 (wdata_a2),
        .WDATA_B2 (wdata_b2),
        .RDATA_A1 (rdata_a1),
        .RDATA_B1 (rdata_b1),
        .RDATA_A2 (rdata_a2),
        .RDATA_B2 (rdata_b2),
        .FLUSH1   (flush1),
        .FLUSH2   (flush2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        rst    = 1'b0;
        wen_a1 = 1'b0; wen_b1 = 1'b0; wen_a2 = 1'b0; wen_b2 = 1'b0;
        ren_a1 = 1'b0; ren_b1 = 1'b0; ren_a2 = 1'b0; ren_b2 = 1'b0;
        flush1 = 1'b0; flush2 = 1'b0;
    endtask

    // One clock edge with the current inputs, then drop all strobes
    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    // Extra cycle for the optional output stage
    task automatic drain();
`ifdef TDP36K_OUT_REG_EN
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        clear_strobes();
        be_a1 = 2'b00; be_b1 = 2'b00; be_a2 = 2'b00; be_b2 = 2'b00;
        addr_a1 = '0; addr_b1 = '0; addr_a2 = '0; addr_b2 = '0;
        wdata_a1 = '0; wdata_b1 = '0; wdata_a2 = '0; wdata_b2 = '0;
        #2;

        // Reset with a write attempt and all reads enabled
        rst = 1'b1; wen_a1 = 1'b1; be_a1 = 2'b11; addr_a1 = 14'h0030; wdata_a1 = 18'h3FFFF;
        ren_a1 = 1'b1; ren_b1 = 1'b1; ren_a2 = 1'b1; ren_b2 = 1'b1;
        @(posedge clk); #1;
        step();
        check("rst_a1", rdata_a1, 18'h00000);
        check("rst_b1", rdata_b1, 18'h00000);
        check("rst_a2", rdata_a2, 18'h00000);
        check("rst_b2", rdata_b2, 18'h00000);

        // RAM1 row 3 untouched by the suppressed write, RAM2 row 3 from INIT
        ren_b1 = 1'b1; addr_b1 = 14'h0030;
        ren_a2 = 1'b1; addr_a2 = 14'h0030;
        step(); drain();
        check("ram1_row3", rdata_b1, 18'h00000);
        check("ram2_row3_init", rdata_a2, 18'h3FFFF);

        // x18 write on A1, x18 read on B1
        wen_a1 = 1'b1; be_a1 = 2'b11; addr_a1 = 14'h0010; wdata_a1 = 18'h2ABCD;
        step();
        ren_b1 = 1'b1; addr_b1 = 14'h0010;
        step(); drain();
        check("x18_wr_rd", rdata_b1, 18'h2ABCD);

        // x18 byte enables: low lane then high lane into row 2
        wen_a1 = 1'b1; be_a1 = 2'b01; addr_a1 = 14'h0020; wdata_a1 = 18'h3FFFF;
        step();
        ren_b1 = 1'b1; addr_b1 = 14'h0020;
        step(); drain();
        check("x18_be01", rdata_b1, 18'h100FF);
        wen_a1 = 1'b1; be_a1 = 2'b10; addr_a1 = 14'h0020; wdata_a1 = 18'h2AB00;
        step();
        ren_b1 = 1'b1; addr_b1 = 14'h0020;
        step(); drain();
        check("x18_be10", rdata_b1, 18'h3ABFF);

        // x9 write on A2 lane 1 of row 0, x18 read on B2
        wen_a2 = 1'b1; be_a2 = 2'b01; addr_a2 = 14'h0008; wdata_a2 = 18'h100A5;
        step();
        ren_b2 = 1'b1; addr_b2 = 14'h0000;
        step(); drain();
        check("x9_lane1", rdata_b2, 18'h2A500);
        // BE[0]=0 blocks an x9 write
        wen_a2 = 1'b1; be_a2 = 2'b00; addr_a2 = 14'h0000; wdata_a2 = 18'h1FFFF;
        step();
        ren_b2 = 1'b1; addr_b2 = 14'h0000;
        step(); drain();
        check("x9_be_gated", rdata_b2, 18'h2A500);
        // x9 lane 0
        wen_a2 = 1'b1; be_a2 = 2'b01; addr_a2 = 14'h0000; wdata_a2 = 18'h10033;
        step();
        ren_b2 = 1'b1; addr_b2 = 14'h0000;
        step(); drain();
        check("x9_lane0", rdata_b2, 18'h3A533);

        // x2 write on B2: row 1, pair 3 -> bits [7:6]
        wen_b2 = 1'b1; be_b2 = 2'b01; addr_b2 = 14'h0016; wdata_b2 = 18'h3FFFF;
        step();
        ren_a2 = 1'b1; addr_a2 = 14'h0010;
        step(); drain();
        check("x2_pair3", rdata_a2, 18'h000C0);

        // x1 write on B1 (row 0 bit 5), x4 reads on A1
        wen_b1 = 1'b1; be_b1 = 2'b01; addr_b1 = 14'h0005; wdata_b1 = 18'h00001;
        step();
        ren_a1 = 1'b1; addr_a1 = 14'h0004;
        step(); drain();
        check("x4_nib1", rdata_a1, 18'h00002);
        ren_a1 = 1'b1; addr_a1 = 14'h0000;
        step(); drain();
        check("x4_nib0", rdata_a1, 18'h00000);
        ren_a1 = 1'b1; addr_a1 = 14'h0007;
        step(); drain();
        check("x4_low_addr_ignored", rdata_a1, 18'h00002);

        // Same-cycle A1 x18 and B1 x1 writes to row 7 bit 0: B wins the overlap
        wen_a1 = 1'b1; be_a1 = 2'b11; addr_a1 = 14'h0070; wdata_a1 = 18'h3FFFF;
        wen_b1 = 1'b1; be_b1 = 2'b01; addr_b1 = 14'h0070; wdata_b1 = 18'h00000;
        step();
        ren_b1 = 1'b1; addr_b1 = 14'h0070;
        step(); drain();
        check("collision_b_wins", rdata_b1, 18'h3FFFE);

        // Read-during-write on B2 (same port) and A2 (cross port): old data
        wen_b2 = 1'b1; be_b2 = 2'b01; addr_b2 = 14'h0010; wdata_b2 = 18'h00003;
        ren_b2 = 1'b1; ren_a2 = 1'b1; addr_a2 = 14'h0010;
        step(); drain();
        check("rdw_same_port_old", rdata_b2, 18'h000C0);
        check("rdw_cross_port_old", rdata_a2, 18'h000C0);
        ren_b2 = 1'b1; addr_b2 = 14'h0010;
        step(); drain();
        check("rdw_new_after", rdata_b2, 18'h000C3);

        // FLUSH1 beats a read, clears only RAM1 read data, writes still land
        flush1 = 1'b1;
        wen_a1 = 1'b1; be_a1 = 2'b11; addr_a1 = 14'h0080; wdata_a1 = 18'h12345;
        ren_a1 = 1'b1; ren_b1 = 1'b1; addr_b1 = 14'h0070;
        step();
        check("flush_a1", rdata_a1, 18'h00000);
        check("flush_b1", rdata_b1, 18'h00000);
        check("flush_keeps_a2", rdata_a2, 18'h000C0);
        check("flush_keeps_b2", rdata_b2, 18'h000C3);
        ren_b1 = 1'b1; addr_b1 = 14'h0080;
        step(); drain();
        check("flush_write_lands", rdata_b1, 18'h12345);

        // Reset clears loaded read data and blocks a write
        rst = 1'b1; wen_a1 = 1'b1; be_a1 = 2'b11; addr_a1 = 14'h0080; wdata_a1 = 18'h00000;
        step();
        check("rst2_a1", rdata_a1, 18'h00000);
        check("rst2_b1", rdata_b1, 18'h00000);
        check("rst2_a2", rdata_a2, 18'h00000);
        check("rst2_b2", rdata_b2, 18'h00000);
        ren_b1 = 1'b1; addr_b1 = 14'h0080;
        step(); drain();
        check("rst_mem_kept", rdata_b1, 18'h12345);

        // Hold with REN=0
        addr_b1 = 14'h0000;
        step(); step();
        check("ren0_hold", rdata_b1, 18'h12345);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
